// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: requester bus for the shared JK bank
// master: drives req_valid/req_lock/req_j/req_k, observes grant and bank state
// slave:  the arbiter; drives req_ready, q, locked, owner_id, applied
interface jk_bank_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_lock;
    logic [NREQ*WIDTH-1:0]   req_j;
    logic [NREQ*WIDTH-1:0]   req_k;
    logic [NREQ-1:0]         req_ready;
    logic [WIDTH-1:0]        q;
    logic                    locked;
    logic [$clog2(NREQ)-1:0] owner_id;
    logic                    applied;
    modport master (
        output req_valid, req_lock, req_j, req_k,
        input  req_ready, q, locked, owner_id, applied
    );
    modport slave (
        input  req_valid, req_lock, req_j, req_k,
        output req_ready, q, locked, owner_id, applied
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter owning a WIDTH-bit JK flip-flop bank
// clk/rst: rising-edge clock, asynchronous active-high reset
// bus (slave): per-requester valid/lock/J/K in, one-hot ready, bank q,
//              locked, owner_id and applied pulse out
module jk_bank_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst,
    jk_bank_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, OWN} state_t;
    state_t          state;
    logic [IW-1:0]   ptr;
    logic [BW-1:0]   bcnt;
    logic [NREQ-1:0] ready;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   idx;
    logic [WIDTH-1:0] j, k;
    logic            accept, lock;
    // Scan offsets high to low so the requester nearest ptr is written last and wins
    always_comb begin
        ready = '0;
        gnt   = bus.owner_id;
        idx   = '0;
        if (!rst && state == OWN) begin
            ready[bus.owner_id] = bus.req_valid[bus.owner_id];
        end else if (!rst) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                idx = IW'((int'(ptr) + i) % NREQ);
                if (bus.req_valid[idx]) begin
                    ready      = '0;
                    ready[idx] = 1'b1;
                    gnt        = idx;
                end
            end
        end
    end
    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IW'(i)) begin
                j = bus.req_j[i*WIDTH +: WIDTH];
                k = bus.req_k[i*WIDTH +: WIDTH];
            end
        end
    end
    assign accept        = |ready;
    assign lock          = bus.req_lock[gnt];
    assign bus.req_ready = ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            bcnt         <= '0;
            bus.q        <= '0;
            bus.locked   <= 1'b0;
            bus.owner_id <= '0;
            bus.applied  <= 1'b0;
        end else begin
            bus.applied <= accept;
            if (accept) begin
                // JK next state: J sets a cleared bit, ~K keeps a set bit
                bus.q        <= (j & ~bus.q) | (~k & bus.q);
                bus.owner_id <= gnt;
                ptr          <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            end
            if (state == IDLE) begin
                if (accept && lock && MAX_BURST > 1) begin
                    state      <= OWN;
                    bus.locked <= 1'b1;
                    bcnt       <= BW'(1);
                end
            end else if (accept && lock && 32'(bcnt) + 1 < MAX_BURST) begin
                bcnt <= bcnt + 1'b1;
            end else begin
                // lock dropped, burst exhausted, or owner went idle
                state      <= IDLE;
                bus.locked <= 1'b0;
                bcnt       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed self-checking bench for jk_bank_arbiter
module tb_jk_bank_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    jk_bank_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();
    jk_bank_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic set_jk(input int i, input logic [7:0] jv, input logic [7:0] kv);
        bus.req_j[i*8 +: 8] = jv;
        bus.req_k[i*8 +: 8] = kv;
    endtask
    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        cyc();
        rst = 1'b0;
    endtask
    initial begin
        bus.req_valid = 4'hF;
        bus.req_lock  = '0;
        bus.req_j     = '0;
        bus.req_k     = '0;
        #1 check("rst_ready", 32'(bus.req_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(bus.q), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_owner", 32'(bus.owner_id), 0);
        check("rst_applied", 32'(bus.applied), 0);
        bus.req_valid = '0;
        rst = 1'b0;
        // single command, then toggle upper nibble
        set_jk(0, 8'hFF, 8'h00);
        bus.req_valid = 4'b0001;
        #1 check("t1_ready", 32'(bus.req_ready), 32'b0001);
        cyc();
        check("t1_q", 32'(bus.q), 32'hFF);
        check("t1_applied", 32'(bus.applied), 1);
        check("t1_owner", 32'(bus.owner_id), 0);
        check("t1_locked", 32'(bus.locked), 0);
        set_jk(0, 8'hF0, 8'hF0);
        #1 check("t1_ready2", 32'(bus.req_ready), 32'b0001);
        cyc();
        check("t1_q2", 32'(bus.q), 32'h0F);
        bus.req_valid = '0;
        cyc();
        check("t1_applied_off", 32'(bus.applied), 0);
        check("t1_q_hold", 32'(bus.q), 32'h0F);
        // round robin, no lock
        do_reset();
        for (int i = 0; i < 4; i++) set_jk(i, 8'h01, 8'h00);
        bus.req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            #1 check("rr_ready", 32'(bus.req_ready), 32'(1) << (n % 4));
            cyc();
            check("rr_owner", 32'(bus.owner_id), 32'(n % 4));
            check("rr_locked", 32'(bus.locked), 0);
        end
        bus.req_valid = '0;
        check("rr_q", 32'(bus.q), 32'h01);
        // locked burst from req 2, bounded at 4 accepts
        do_reset();
        set_jk(1, 8'h80, 8'h00);
        bus.req_valid = 4'b0010;
        #1 check("b_pre_ready", 32'(bus.req_ready), 32'b0010);
        cyc();
        set_jk(2, 8'h01, 8'h01);
        set_jk(3, 8'h02, 8'h00);
        bus.req_valid = 4'b1110;
        bus.req_lock  = 4'b0100;
        for (int n = 1; n <= 4; n++) begin
            #1 check("b_ready", 32'(bus.req_ready), 32'b0100);
            cyc();
            check("b_locked", 32'(bus.locked), (n < 4) ? 1 : 0);
            check("b_owner", 32'(bus.owner_id), 2);
            check("b_q", 32'(bus.q), (n % 2 == 1) ? 32'h81 : 32'h80);
        end
        #1 check("b_next_ready", 32'(bus.req_ready), 32'b1000);
        bus.req_lock = '0;
        cyc();
        check("b_next_q", 32'(bus.q), 32'h82);
        check("b_next_owner", 32'(bus.owner_id), 3);
        // owner drops valid: one idle cycle, then req 2 granted
        set_jk(1, 8'h00, 8'h00);
        set_jk(2, 8'h00, 8'h00);
        bus.req_valid = 4'b0010;
        bus.req_lock  = 4'b0010;
        #1 check("d_ready", 32'(bus.req_ready), 32'b0010);
        cyc();
        check("d_locked", 32'(bus.locked), 1);
        check("d_owner", 32'(bus.owner_id), 1);
        bus.req_valid = 4'b0100;
        #1 check("d_drop_ready", 32'(bus.req_ready), 0);
        cyc();
        check("d_drop_locked", 32'(bus.locked), 0);
        check("d_drop_applied", 32'(bus.applied), 0);
        #1 check("d_next_ready", 32'(bus.req_ready), 32'b0100);
        cyc();
        check("d_next_owner", 32'(bus.owner_id), 2);
        check("d_next_applied", 32'(bus.applied), 1);
        bus.req_valid = '0;
        bus.req_lock  = '0;
        // asynchronous reset in the middle of a burst
        do_reset();
        set_jk(0, 8'hA5, 8'h00);
        bus.req_valid = 4'b0001;
        bus.req_lock  = 4'b0001;
        cyc();
        check("r_q", 32'(bus.q), 32'hA5);
        check("r_locked", 32'(bus.locked), 1);
        rst = 1'b1;
        #1;
        check("r_async_q", 32'(bus.q), 0);
        check("r_async_locked", 32'(bus.locked), 0);
        check("r_async_ready", 32'(bus.req_ready), 0);
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        bus.req_lock  = '0;
        #1 check("r_after_ready", 32'(bus.req_ready), 32'b0001);
        cyc();
        check("r_after_owner", 32'(bus.owner_id), 0);
        // toggle stress
        do_reset();
        set_jk(0, 8'hFF, 8'hFF);
        bus.req_valid = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("tg_q", 32'(bus.q), (n % 2 == 0) ? 32'hFF : 32'h00);
        end
        bus.req_valid = '0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
